// File: rtl/led_pkg.sv
// Shared segment-pattern constants for the LED scan path.
// Holds the active-low seven-segment encodings of 0..F, the blank pattern,
// the dp bit index and the decoder result struct.
package led_pkg;

  localparam int DP_BIT = 7;

  // seg_n[6:0] = g..a, active-low
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h58;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       err;
  } seg_dec_t;

endpackage

// File: rtl/led_scan_reader_if.sv
// Bundle between a multiplexed display bus / frame consumer and the scan reader.
// master: drives seg_n, an_n, frame_ready and receives the decoded frame.
// slave : the reader; samples the display bus and presents frames.
interface led_scan_reader_if #(
  parameter int NUM_DIGITS = 8
);
  logic [7:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   err_mask;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    frame_valid;
  logic                    frame_ready;
  logic                    overrun;

  modport master (
    output seg_n, an_n, frame_ready,
    input  value, blank_mask, err_mask, dp_mask, frame_valid, overrun
  );

  modport slave (
    input  seg_n, an_n, frame_ready,
    output value, blank_mask, err_mask, dp_mask, frame_valid, overrun
  );
endinterface

// File: rtl/led_pattern_decoder.sv
// Combinational seven-segment pattern decoder: seg_n[6:0] -> nibble/blank/err.
// Latency: zero cycles. Backpressure: none.
// Ports: i_seg_n (active-low g..a), o_dec (nibble, blank flag, unrecognised flag).
module led_pattern_decoder
  import led_pkg::*;
(
  input  logic [6:0] i_seg_n,
  output seg_dec_t   o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_seg_n)
      SEG_0:     o_dec.nibble = 4'h0;
      SEG_1:     o_dec.nibble = 4'h1;
      SEG_2:     o_dec.nibble = 4'h2;
      SEG_3:     o_dec.nibble = 4'h3;
      SEG_4:     o_dec.nibble = 4'h4;
      SEG_5:     o_dec.nibble = 4'h5;
      SEG_6:     o_dec.nibble = 4'h6;
      SEG_7:     o_dec.nibble = 4'h7;
      SEG_8:     o_dec.nibble = 4'h8;
      SEG_9:     o_dec.nibble = 4'h9;
      SEG_A:     o_dec.nibble = 4'hA;
      SEG_B:     o_dec.nibble = 4'hB;
      SEG_C:     o_dec.nibble = 4'hC;
      SEG_D:     o_dec.nibble = 4'hD;
      SEG_E:     o_dec.nibble = 4'hE;
      SEG_F:     o_dec.nibble = 4'hF;
      SEG_BLANK: o_dec.blank  = 1'b1;
      default:   o_dec.err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/led_scan_reader.sv
// Recovers hex digits from a multiplexed active-low 7-seg bus into packed frames.
// Latency: digit captured SETTLE_CYCLES-1 edges after first sample; frame valid right after last capture.
// Backpressure: frame held until frame_valid&&frame_ready; a newer frame overwrites it and sets sticky overrun.
// Ports: clk, rst (sync, active-high), bus (slave modport: seg_n, an_n, frame_ready in;
//        value, blank_mask, err_mask, dp_mask, frame_valid, overrun out).
// Optional feature macro LED_SCAN_READER_DP_EN: decode dp into dp_mask and include it in stability.
module led_scan_reader
  import led_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  led_scan_reader_if.slave  bus
);

`ifdef LED_SCAN_READER_DP_EN
  localparam int SW = 8;
`else
  localparam int SW = 7;
`endif
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE_CYCLES);

  logic [NUM_DIGITS-1:0]   r_an_prev;
  logic [SW-1:0]           r_seg_prev;
  logic [CW-1:0]           r_cnt;
  logic [4*NUM_DIGITS-1:0] r_sh_val;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic [NUM_DIGITS-1:0]   r_sh_err;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [NUM_DIGITS-1:0]   r_err;
  logic                    r_valid;
  logic                    r_ovr;

  logic [SW-1:0]           w_seg_cmp;
  logic [NUM_DIGITS-1:0]   w_act;
  logic                    w_onehot;
  logic                    w_same;
  logic [CW-1:0]           w_cnt_nxt;
  logic                    w_cap;
  logic [IW-1:0]           w_idx;
  seg_dec_t                w_dec;
  logic [4*NUM_DIGITS-1:0] w_sh_val_nxt;
  logic [NUM_DIGITS-1:0]   w_sh_blank_nxt;
  logic [NUM_DIGITS-1:0]   w_sh_err_nxt;
  logic [NUM_DIGITS-1:0]   w_seen_nxt;
  logic                    w_done;
  logic                    w_accept;

  assign w_seg_cmp = bus.seg_n[SW-1:0];

  // Exactly one anode low: nonzero and a power of two after inversion.
  assign w_act    = ~bus.an_n;
  assign w_onehot = (w_act != '0) && ((w_act & (w_act - NUM_DIGITS'(1))) == '0);
  assign w_same   = (bus.an_n == r_an_prev) && (w_seg_cmp == r_seg_prev);

  always_comb begin
    w_cnt_nxt = '0;
    if (w_same && w_onehot)
      w_cnt_nxt = (r_cnt == SETTLE_C) ? r_cnt : r_cnt + CW'(1);
    else if (w_onehot)
      w_cnt_nxt = CW'(1);
  end

  // Capture only on the edge the counter arrives at SETTLE; a saturated run stays quiet.
  assign w_cap = w_onehot && (w_cnt_nxt == SETTLE_C) && !(w_same && (r_cnt == SETTLE_C));

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (w_act[i]) w_idx = IW'(i);
  end

  led_pattern_decoder u_dec (
    .i_seg_n (bus.seg_n[6:0]),
    .o_dec   (w_dec)
  );

  // Shadow update merged with this cycle's capture so a completing frame
  // can be published on the same edge that captures its last digit.
  always_comb begin
    w_sh_val_nxt   = r_sh_val;
    w_sh_blank_nxt = r_sh_blank;
    w_sh_err_nxt   = r_sh_err;
    w_seen_nxt     = r_seen;
    if (w_cap) begin
      w_sh_val_nxt[w_idx*4 +: 4] = w_dec.nibble;
      w_sh_blank_nxt[w_idx]      = w_dec.blank;
      w_sh_err_nxt[w_idx]        = w_dec.err;
      w_seen_nxt[w_idx]          = 1'b1;
    end
  end

  assign w_done   = &w_seen_nxt;
  assign w_accept = r_valid && bus.frame_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an_prev  <= '0;
      r_seg_prev <= '0;
      r_cnt      <= '0;
      r_sh_val   <= '0;
      r_sh_blank <= '0;
      r_sh_err   <= '0;
      r_seen     <= '0;
      r_value    <= '0;
      r_blank    <= '0;
      r_err      <= '0;
      r_valid    <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_an_prev  <= bus.an_n;
      r_seg_prev <= w_seg_cmp;
      r_cnt      <= w_cnt_nxt;
      r_sh_val   <= w_sh_val_nxt;
      r_sh_blank <= w_sh_blank_nxt;
      r_sh_err   <= w_sh_err_nxt;
      r_seen     <= w_done ? '0 : w_seen_nxt;
      if (w_done) begin
        r_value <= w_sh_val_nxt;
        r_blank <= w_sh_blank_nxt;
        r_err   <= w_sh_err_nxt;
      end
      r_valid <= w_done || (r_valid && !bus.frame_ready);
      if (w_done && r_valid && !bus.frame_ready)
        r_ovr <= 1'b1;
      else if (w_accept)
        r_ovr <= 1'b0;
    end
  end

`ifdef LED_SCAN_READER_DP_EN
  logic [NUM_DIGITS-1:0] r_sh_dp;
  logic [NUM_DIGITS-1:0] r_dp;
  logic [NUM_DIGITS-1:0] w_sh_dp_nxt;

  always_comb begin
    w_sh_dp_nxt = r_sh_dp;
    if (w_cap) w_sh_dp_nxt[w_idx] = ~bus.seg_n[DP_BIT];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_dp <= '0;
      r_dp    <= '0;
    end else begin
      r_sh_dp <= w_sh_dp_nxt;
      if (w_done) r_dp <= w_sh_dp_nxt;
    end
  end

  assign bus.dp_mask = r_dp;
`else
  // dp line is deliberately ignored in this build.
  logic w_unused_dp;
  assign w_unused_dp = bus.seg_n[DP_BIT];
  assign bus.dp_mask = '0;
`endif

  assign bus.value       = r_value;
  assign bus.blank_mask  = r_blank;
  assign bus.err_mask    = r_err;
  assign bus.frame_valid = r_valid;
  assign bus.overrun     = r_ovr;

endmodule

// File: doc/led_scan_reader.md
# led_scan_reader

Recovers hex digits from a multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode enables) and presents each completed frame as a packed value with a valid/ready handshake. It is the reading end of the display path: it sits beside the display driver, either in the self-check harness or on a board monitoring an external display, and turns scanned segment patterns back into nibbles. It also flags blank digits, unrecognised patterns and frames dropped by a stalled consumer.

## Interface
- `NUM_DIGITS`, default 8: number of multiplexed digits; `value` width is 4*NUM_DIGITS.
- `SETTLE_CYCLES`, default 4, minimum 1: consecutive identical samples required before a digit is captured.
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `seg_n`  in  8  segment bus, active-low; bit7 = dp, bits6..0 = g..a.
- `an_n`  in  NUM_DIGITS  digit enables, active-low; exactly one low = a digit being shown.
- `value`  out  4*NUM_DIGITS  decoded nibbles; digit i at bits [4i+3:4i].
- `blank_mask`  out  NUM_DIGITS  1 = digit i was blank.
- `err_mask`  out  NUM_DIGITS  1 = digit i showed an unrecognised pattern.
- `dp_mask`  out  NUM_DIGITS  1 = dp lit on digit i (see Configuration).
- `frame_valid`  out  1  a frame is held on the outputs.
- `frame_ready`  in  1  consumer accepts the frame.
- `overrun`  out  1  sticky flag: an unaccepted frame was overwritten.

## Operation
- Pattern set, seg_n[6:0] to nibble: 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x58→7, 0x00→8, 0x10→9, 0x08→A, 0x03→b, 0x46→C, 0x21→d, 0x06→E, 0x0E→F.
- Blank pattern: 0x7F gives nibble 0 and sets the blank bit.
- Any other pattern gives nibble 0 and sets the err bit.
- Stability tracking:
  - Each cycle the (an_n, seg_n) pair is compared with the previous cycle's pair.
  - If they are equal and an_n is one-hot-low, the stability counter increments, saturating at SETTLE_CYCLES.
  - Otherwise the counter is reset to 1 if an_n is one-hot-low, or to 0 if it is not.
- Digit capture:
  - A digit is captured once per stable run, when the counter reaches SETTLE_CYCLES.
  - Capture writes the decoded nibble and the blank/err/dp flags into shadow registers and sets `seen[i]`.
  - Recapturing a digit that is already seen overwrites its shadow entry.
- Frame completion: when all `seen` bits are set, shadow is copied to the outputs, `frame_valid` is set, and `seen` is cleared, all in the same edge.
- Handshake:
  - `frame_valid` stays high and the outputs stay stable until a cycle with `frame_valid && frame_ready`.
  - On that cycle `frame_valid` drops next edge, unless a new frame completes on the same edge.
- Overrun:
  - A frame completing while `frame_valid && !frame_ready` overwrites the outputs and sets `overrun`.
  - A frame completing on the accepting cycle does not set `overrun`; `frame_valid` stays 1.
  - `overrun` clears on the next accepted handshake, unless the same edge also sets it.
- Zero or multiple anodes low: treated as a glitch. No capture, and the counter is handled as above.

## Timing
- Reset value of every output is 0; the shadow registers, `seen` and the counter also clear.
- Reset mid-frame discards the partial frame.
- Capture latency:
  - A pair first sampled at edge k and held is captured at edge k+SETTLE_CYCLES-1.
  - With SETTLE_CYCLES=1, the digit is captured at the first edge it is sampled.
- Frame latency: `frame_valid` is high immediately after the edge that captures the last unseen digit.
- Throughput: one frame is accepted per cycle at most. Inputs are sampled directly, with no input synchroniser; the caller synchronises asynchronous buses.

## Configuration
- `LED_SCAN_READER_DP_EN` defined: seg_n[7] low sets `dp_mask[i]`; dp state is part of the stability comparison.
- Not defined: `dp_mask` is tied to 0, seg_n[7] is ignored in both the comparison and the decode, and the dp shadow registers are not built.

## Structure
- Shared package `led_pkg`: the sixteen segment pattern constants, `SEG_BLANK` (7'h7F) and the `DP_BIT` index.
- Sub-module `led_pattern_decoder`: combinational, seg_n[6:0] → nibble, blank and err. Instantiated once, on the current sample.
- Top level holds:
  - the sample registers and stability counter
  - the one-hot check and anode-to-index encoder
  - the shadow registers, `seen`, and the output/handshake registers

## Test plan
- Scan digits 0..7 showing 0x01234567 patterns, held 4 cycles each, with `frame_ready`=1 → `value`=0x76543210 ordering per bit mapping, `frame_valid` pulses one cycle, masks 0.
- Digit 3 shows 0x7F and digit 5 shows 0x55, others valid → `blank_mask`=0x08, `err_mask`=0x20, nibbles 3 and 5 are 0.
- Digit held only 3 cycles with SETTLE_CYCLES=4, or two anodes low together → no capture, `frame_valid` stays 0.
- `frame_ready`=0 while two frames complete → second frame on the outputs, `overrun`=1; the next handshake clears both.
- A frame completes on the same cycle as `frame_ready`=1 → `frame_valid` stays 1, `overrun` stays 0, new value shown.
- `rst` asserted after 5 digits are captured, then a full scan → only the post-reset frame is reported. Also check `dp_mask` with and without `LED_SCAN_READER_DP_EN` (dp low on digit 2 → 0x04 or 0x00).
